// File: rtl/sweep_sequencer.sv
`timescale 1ns / 1ps
// sweep_sequencer
//
// Drives an external up/down counter through a number of triangle sweeps
// between a low bound and a high bound. A sequence first seeks the counter to
// the low bound, then runs lo -> hi -> lo once per period, then parks at lo.
// The counter is outside this block: it is steered through cnt_enable and
// cnt_updown, and its count is observed on cnt_value.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   cmd_valid    command request, taken when cmd_ready is high
//   cmd_ready    high exactly when idle
//   cmd_lo       sweep low bound
//   cmd_hi       sweep high bound (must be above cmd_lo)
//   cmd_periods  number of full sweeps (must be non-zero)
//   abort        stop the running sequence (ignored when idle)
//   cnt_value    current count of the external counter
//   cnt_enable   counter enable (registered)
//   cnt_updown   counter direction, 1 = up (registered)
//   busy         high while a sequence is running
//   done         one-cycle pulse when a sequence completes
//   err          one-cycle pulse when a command is rejected
//   aborted      one-cycle pulse when a sequence is aborted

module sweep_sequencer #(
    parameter int WIDTH = 8,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    input  logic [PW-1:0]    cmd_periods,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_enable,
    output logic             cnt_updown,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        UP,
        DOWN
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P = PW'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] lo, lo_nx;
    logic [WIDTH-1:0] hi, hi_nx;
    logic [PW-1:0]    rem, rem_nx;
    logic             enable_nx, updown_nx, done_nx, err_nx, aborted_nx;

    logic [WIDTH-1:0] lo_m1, lo_p1, hi_m1;
    logic             onto_lo;

    assign lo_m1 = lo - ONE_W;
    assign lo_p1 = lo + ONE_W;
    assign hi_m1 = hi - ONE_W;

    // The counter lands on lo at this very edge, so the seek is already over
    // and the first upward step must be issued now rather than one edge late.
    assign onto_lo = cnt_enable &&
                     (( cnt_updown && (cnt_value == lo_m1)) ||
                      (!cnt_updown && (cnt_value == lo_p1)));

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves a value unassigned and infers a latch.
        state_nx   = state;
        lo_nx      = lo;
        hi_nx      = hi;
        rem_nx     = rem;
        enable_nx  = cnt_enable;
        updown_nx  = cnt_updown;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        aborted_nx = 1'b0;

        unique case (state)
            IDLE: begin
                enable_nx = 1'b0;
                if (cmd_valid) begin
                    if ((cmd_hi <= cmd_lo) || (cmd_periods == '0)) begin
                        err_nx = 1'b1;
                    end else begin
                        lo_nx    = cmd_lo;
                        hi_nx    = cmd_hi;
                        rem_nx   = cmd_periods;
                        state_nx = SEEK;
                    end
                end
            end

            SEEK: begin
                enable_nx = 1'b1;
                if ((cnt_value == lo) || onto_lo) begin
                    updown_nx = 1'b1;
                    state_nx  = UP;
                end else begin
                    updown_nx = (cnt_value < lo);
                end
            end

            UP: begin
                // The step taken at this edge reaches hi; turn around so hi is
                // held for exactly one cycle.
                if (cnt_value == hi_m1) begin
                    updown_nx = 1'b0;
                    state_nx  = DOWN;
                end
            end

            DOWN: begin
                if (cnt_value == lo_p1) begin
                    rem_nx = rem - ONE_P;
                    if (rem == ONE_P) begin
                        enable_nx = 1'b0;
                        done_nx   = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        updown_nx = 1'b1;
                        state_nx  = UP;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase

        // Abort wins over any transition taken above, including completion.
        if (abort && (state != IDLE)) begin
            rem_nx     = rem;
            enable_nx  = 1'b0;
            done_nx    = 1'b0;
            aborted_nx = 1'b1;
            state_nx   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            lo         <= '0;
            hi         <= '0;
            rem        <= '0;
            cnt_enable <= 1'b0;
            cnt_updown <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state      <= state_nx;
            lo         <= lo_nx;
            hi         <= hi_nx;
            rem        <= rem_nx;
            cnt_enable <= enable_nx;
            cnt_updown <= updown_nx;
            done       <= done_nx;
            err        <= err_nx;
            aborted    <= aborted_nx;
        end
    end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

- Controller that sequences the 8-bit up/down counter through a programmed number of triangle sweeps between a low bound `lo` and a high bound `hi`.
- The counter first seeks to `lo`, then sweeps `lo` → `hi` → `lo` `periods` times, then parks at `lo`.
- Sits between a command master and the counter instance. It drives the counter's enable and direction inputs and observes its count.

## Interface

Parameters:
- `WIDTH`, default 8: counter and bound width.
- `PW`, default 8: width of the period-count field.

Ports (one clock `clk`; reset `rstn` is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high exactly when in IDLE.
- `cmd_lo` in WIDTH: sweep low bound.
- `cmd_hi` in WIDTH: sweep high bound.
- `cmd_periods` in PW: number of full sweeps.
- `abort` in 1: stop the current sequence.
- `cnt_value` in WIDTH: counter output.
- `cnt_enable` out 1: counter enable, registered.
- `cnt_updown` out 1: counter direction, 1 = up, registered.
- `busy` out 1: high when not in IDLE.
- `done` out 1: one-cycle pulse when a sequence completes.
- `err` out 1: one-cycle pulse when a command is rejected.
- `aborted` out 1: one-cycle pulse when a sequence is aborted.

## Operation

Counter model:
- On each `clk` edge with `cnt_enable`=1, the count steps by ±1, modulo 2^WIDTH.
- Reset value of the count is 0.

Reset: all outputs 0 except `cmd_ready`=1. State is IDLE.

Command acceptance, at an edge with `cmd_valid` && `cmd_ready`:
- The command is rejected if `cmd_hi` <= `cmd_lo` (unsigned) or `cmd_periods`=0. In that case `err` pulses on the next cycle and the state stays IDLE.
- Otherwise `lo`, `hi` and `periods` are latched, the remaining-period counter `rem` is loaded with `periods`, and the state moves to SEEK.

States and transitions (evaluated each edge, using the `cnt_value` sampled at that edge):
- IDLE:
  - `cnt_enable`=0.
  - `cmd_valid` while not in IDLE is ignored (`cmd_ready`=0).
- SEEK:
  - If `cnt_value`=`lo`, or the counter is stepping onto `lo` at this edge, then set `cnt_enable`<=1 and `cnt_updown`<=1, and go to UP. "Stepping onto `lo`" means enable=1 with up and value=`lo`-1, or enable=1 with down and value=`lo`+1.
  - Otherwise set `cnt_enable`<=1 and `cnt_updown`<=(`cnt_value` < `lo`).
- UP:
  - If `cnt_value`=`hi`-1, the counter reaches `hi` at this edge. Set `cnt_updown`<=0 and go to DOWN.
- DOWN:
  - If `cnt_value`=`lo`+1, the counter reaches `lo` at this edge and `rem` decrements.
  - If `rem` was 1: set `cnt_enable`<=0, `done`<=1 and go to IDLE.
  - Otherwise set `cnt_updown`<=1 and go to UP.
- Abort: `abort`=1 in SEEK, UP or DOWN takes priority over every transition above. It sets `cnt_enable`<=0, pulses `aborted` and goes to IDLE. `abort` in IDLE is ignored.

Boundary rules:
- `hi`=`lo`+1 is legal. UP lasts one edge and DOWN lasts one edge.
- The count never overshoots `hi` or undershoots `lo` during sweeps. `hi` is held for exactly one cycle at each peak.
- The `lo`/`hi` comparisons are unsigned. `lo`=0 and `hi`=2^WIDTH-1 are legal, and no wrap-around ever occurs.
- Reset asserted mid-sequence forces IDLE and zeroes all outputs immediately (asynchronously).

## Timing

- `cnt_enable`, `cnt_updown`, `done`, `err` and `aborted` are registered. Each changes one edge after the condition that causes it.
- Let E0 be the acceptance edge and d = |count at E1 − `lo`|:
  - UP is entered at edge E(1+d).
  - Each period takes 2·(`hi`−`lo`) edges.
  - `done` rises at edge E(1 + d + 2·`periods`·(`hi`−`lo`)) and is high for one cycle.
- After `done` or `aborted`, `cmd_ready`=1 on the same cycle, so a new command can be accepted on the next edge.
- After an abort the count freezes at its value from the abort edge.

## Test plan

- Reset, then command `lo`=0, `hi`=3, `periods`=2:
  - Count over consecutive cycles from E2 reads 0,1,2,3,2,1,0,1,2,3,2,1,0.
  - `done` pulses at E13, then the count holds at 0 and `busy`=0.
- With the count at 0, command `lo`=5, `hi`=7, `periods`=1:
  - The seek takes 5 edges.
  - The count then reads 5,6,7,6,5.
  - `done` pulses at E10.
- Rejected commands:
  - `hi`=`lo`=4: `err` pulses for one cycle.
  - `periods`=0: `err` pulses for one cycle.
  - In both cases `cnt_enable` stays 0 and `busy` stays 0.
- `lo`=10, `hi`=11, `periods`=3: the count alternates 10,11 three times, then `done` pulses and the count holds at 10.
- Abort during a sweep:
  - Command `lo`=0, `hi`=100, `periods`=1; assert `abort` when the count is 40 while in UP.
  - `aborted` pulses, `cnt_enable`=0 on the next cycle, the count freezes at 41, and no `done` pulse occurs.
  - A subsequent command is accepted normally.
- Reset mid-sequence:
  - Drive `rstn`=0 mid-sweep.
  - All outputs go to 0 immediately, except `cmd_ready`, which goes to 1.
  - `cmd_valid` during a sequence is ignored.
